// File: rtl/lb_window_mux.sv
// lb_window_mux: local-bus window decoder with a latency-aligned read-data return mux and hit/miss counters
module lb_window_mux #(
  parameter int n_win = 4,
  parameter int aw = 24,
  parameter int dw = 32,
  parameter int sel_msb = 23,
  parameter int sel_lsb = 20,
  parameter logic [n_win*(sel_msb-sel_lsb+1)-1:0] win_ids = {4'd4, 4'd3, 4'd2, 4'd1},
  parameter logic [sel_msb-sel_lsb:0] base_id = '0,
  parameter int rd_lat = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [aw-1:0]       lb_addr,
  input  logic                lb_strobe,
  input  logic                lb_rd,
  output logic [n_win-1:0]    win_write,
  output logic [n_win-1:0]    win_read,
  input  logic [n_win*dw-1:0] win_data_in,
  input  logic [dw-1:0]       base_data_in,
  output logic [dw-1:0]       mux_data,
  output logic                mux_valid,
  input  logic                clr_counts,
  output logic [n_win*16-1:0] rd_count,
  output logic [15:0]         miss_count
);
  localparam int sw = sel_msb - sel_lsb + 1;
  localparam int iw = $clog2(n_win + 2);
  localparam logic [iw-1:0] base_idx = iw'(n_win);
  localparam logic [iw-1:0] miss_idx = iw'(n_win + 1);
  localparam logic [dw-1:0] miss_val = dw'(32'hbadc0de0);
  if (rd_lat < 1) begin : g_bad_lat
    $error("lb_window_mux: rd_lat must be >= 1");
  end
  logic [sw-1:0] sel;
  logic [iw-1:0] idx;
  logic [iw-1:0] pipe [rd_lat];
  logic [rd_lat-1:0] vpipe;
  logic unused_addr;
  assign sel = lb_addr[sel_msb:sel_lsb];
  assign unused_addr = ^lb_addr;
  // Descending scan so the lowest-indexed window wins on overlapping IDs
  always_comb begin
    idx = sel == base_id ? base_idx : miss_idx;
    for (int i = n_win - 1; i >= 0; i--)
      if (sel == win_ids[i*sw+:sw]) idx = iw'(i);
  end
  for (genvar i = 0; i < n_win; i++) begin : g_win
    logic [15:0] cnt;
    assign win_write[i] = lb_strobe & ~lb_rd & (idx == iw'(i));
    assign win_read[i] = lb_strobe & lb_rd & (idx == iw'(i));
    assign rd_count[i*16+:16] = cnt;
    always_ff @(posedge clk)
      cnt <= rst | clr_counts ? 16'd0 : win_read[i] && cnt != 16'hffff ? cnt + 16'd1 : cnt;
  end
  always_ff @(posedge clk)
    miss_count <= rst | clr_counts ? 16'd0
                : lb_strobe && idx == miss_idx && miss_count != 16'hffff ? miss_count + 16'd1
                : miss_count;
  // The select pipe shifts every cycle so the mux tracks the address even without a strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < rd_lat; k++) pipe[k] <= base_idx;
      vpipe <= '0;
    end else begin
      pipe[0] <= idx;
      for (int k = 1; k < rd_lat; k++) pipe[k] <= pipe[k-1];
      vpipe <= (vpipe << 1) | rd_lat'(lb_strobe & lb_rd);
    end
  end
  assign mux_valid = vpipe[rd_lat-1];
  always_comb begin
    mux_data = pipe[rd_lat-1] == base_idx ? base_data_in : miss_val;
    for (int i = 0; i < n_win; i++)
      if (pipe[rd_lat-1] == iw'(i)) mux_data = win_data_in[i*dw+:dw];
  end
endmodule

// File: tb/tb_lb_window_mux.sv
// tb_lb_window_mux: directed checks of decode, aligned read return, counters and reset on three configurations
module tb_lb_window_mux;
  logic clk = 0, rst = 1, lb_strobe = 0, lb_rd = 0, clr_counts = 0;
  logic [23:0] lb_addr = '0;
  logic [31:0] base_data_in = 32'h12345678;
  logic [31:0] w0 = 32'ha0a00000, w1 = 32'hb1b11111, w2 = 32'hc2c22222, w3 = 32'hd3d33333;
  logic [31:0] v0 = 32'hdddd0000, v1 = 32'heeee0001;
  logic [127:0] win_data_in;
  logic [63:0] v_data_in;
  logic [3:0] a_write, a_read, c_write, c_read;
  logic [1:0] b_write, b_read;
  logic [31:0] a_data, b_data, c_data;
  logic a_valid, b_valid, c_valid;
  logic [63:0] a_cnt, c_cnt;
  logic [31:0] b_cnt;
  logic [15:0] a_miss, b_miss, c_miss;
  int n_chk = 0, n_fail = 0;
  assign win_data_in = {w3, w2, w1, w0};
  assign v_data_in = {v1, v0};
  always #5 clk = ~clk;

  lb_window_mux u_a (
    .clk(clk), .rst(rst), .lb_addr(lb_addr), .lb_strobe(lb_strobe), .lb_rd(lb_rd),
    .win_write(a_write), .win_read(a_read), .win_data_in(win_data_in), .base_data_in(base_data_in),
    .mux_data(a_data), .mux_valid(a_valid), .clr_counts(clr_counts), .rd_count(a_cnt), .miss_count(a_miss)
  );
  lb_window_mux #(.n_win(2), .win_ids(8'h11), .rd_lat(1)) u_b (
    .clk(clk), .rst(rst), .lb_addr(lb_addr), .lb_strobe(lb_strobe), .lb_rd(lb_rd),
    .win_write(b_write), .win_read(b_read), .win_data_in(v_data_in), .base_data_in(base_data_in),
    .mux_data(b_data), .mux_valid(b_valid), .clr_counts(clr_counts), .rd_count(b_cnt), .miss_count(b_miss)
  );
  lb_window_mux #(.rd_lat(3)) u_c (
    .clk(clk), .rst(rst), .lb_addr(lb_addr), .lb_strobe(lb_strobe), .lb_rd(lb_rd),
    .win_write(c_write), .win_read(c_read), .win_data_in(win_data_in), .base_data_in(base_data_in),
    .mux_data(c_data), .mux_valid(c_valid), .clr_counts(clr_counts), .rd_count(c_cnt), .miss_count(c_miss)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("reset data", a_data, 32'h12345678);
    check("reset valid", 32'(a_valid), 32'd0);
    check("reset cnt lo", a_cnt[31:0], 32'd0);
    check("reset cnt hi", a_cnt[63:32], 32'd0);
    check("reset miss", 32'(a_miss), 32'd0);
    // write to window 2
    lb_addr = 24'h300010; lb_strobe = 1; lb_rd = 0;
    #1;
    check("wr win_write", 32'(a_write), 32'h4);
    check("wr win_read", 32'(a_read), 32'h0);
    @(negedge clk);
    lb_strobe = 0; lb_addr = '0;
    #1;
    check("wr strobe gone", 32'(a_write), 32'h0);
    check("wr not counted", a_cnt[47:32], 32'd0);
    // back-to-back reads: window 0, window 1, base
    @(negedge clk);
    lb_addr = 24'h100000; lb_strobe = 1; lb_rd = 1;
    #1;
    check("ovl win_read", 32'(b_read), 32'h1);
    check("rd win_read", 32'(a_read), 32'h1);
    @(negedge clk);
    check("lat1 data", b_data, v0);
    check("lat1 valid", 32'(b_valid), 32'd1);
    lb_addr = 24'h200000;
    @(negedge clk);
    check("b2b data0", a_data, w0);
    check("b2b valid0", 32'(a_valid), 32'd1);
    check("lat1 miss data", b_data, 32'hbadc0de0);
    lb_addr = 24'h000004;
    @(negedge clk);
    check("b2b data1", a_data, w1);
    check("b2b valid1", 32'(a_valid), 32'd1);
    check("lat3 data0", c_data, w0);
    check("lat3 valid0", 32'(c_valid), 32'd1);
    lb_strobe = 0; lb_addr = '0;
    @(negedge clk);
    check("b2b data2", a_data, 32'h12345678);
    check("b2b valid2", 32'(a_valid), 32'd1);
    @(negedge clk);
    check("b2b valid end", 32'(a_valid), 32'd0);
    check("rd_count0", a_cnt[15:0], 32'd1);
    check("rd_count1", a_cnt[31:16], 32'd1);
    check("rd_count2", a_cnt[47:32], 32'd0);
    // unmapped read
    lb_addr = 24'hf00000; lb_strobe = 1; lb_rd = 1;
    @(negedge clk);
    lb_strobe = 0; lb_addr = '0;
    @(negedge clk);
    check("miss data", a_data, 32'hbadc0de0);
    check("miss valid", 32'(a_valid), 32'd1);
    check("miss count", 32'(a_miss), 32'd1);
    // clear wins over a same-cycle increment
    lb_addr = 24'h300000; lb_strobe = 1; lb_rd = 1; clr_counts = 1;
    @(negedge clk);
    lb_strobe = 0; clr_counts = 0; lb_addr = '0;
    @(negedge clk);
    check("clr vs inc", a_cnt[47:32], 32'd0);
    check("clr cnt0", a_cnt[15:0], 32'd0);
    check("clr miss", 32'(a_miss), 32'd0);
    // saturation on window 2
    lb_addr = 24'h300000; lb_strobe = 1; lb_rd = 1;
    repeat (65534) @(negedge clk);
    check("cnt fffe", a_cnt[47:32], 32'h0000fffe);
    repeat (4466) @(negedge clk);
    lb_strobe = 0; lb_addr = '0;
    check("cnt sat", a_cnt[47:32], 32'h0000ffff);
    @(negedge clk);
    check("cnt hold", a_cnt[47:32], 32'h0000ffff);
    check("cnt3 idle", a_cnt[63:48], 32'd0);
    clr_counts = 1;
    @(negedge clk);
    clr_counts = 0;
    check("clr alone", a_cnt[47:32], 32'd0);
    // reset in the same cycle as a rd_lat=3 read
    lb_addr = 24'h100000; lb_strobe = 1; lb_rd = 1; rst = 1;
    @(negedge clk);
    rst = 0; lb_strobe = 0; lb_addr = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst drop valid", 32'(c_valid), 32'd0);
    end
    check("rst base data", c_data, 32'h12345678);
    check("rst cnt0", c_cnt[15:0], 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
